// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: IF-stage fetch sequencer.
// Owns the PC, issues one fetch at a time on the instruction request/response
// interface, applies branch and exception redirects (cancelling an in-flight
// fetch), and holds the fetched instruction until decode accepts it.
// Optional feature macro: PC_ALIGN_CHECK_EN -- when defined, a misaligned PC
// is not fetched; an address-error entry (if_adel=1) is delivered instead.
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        flush,
   input  logic [31:0] flush_target,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        if_adel
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_HOLD = 2'd3;

   logic [1:0]  state;
   logic [31:0] pc;
   logic        cancel;

   logic        redirect;
   logic [31:0] target;
   logic [31:0] pc_inc;
   logic        misaligned;
   logic        deliver;
   logic        adel_hit;
   logic        consume;

   // flush outranks br_taken when both are raised together
   assign redirect = flush | br_taken;
   assign target   = flush ? flush_target : br_target;
   assign pc_inc   = pc + 32'd4;

`ifdef PC_ALIGN_CHECK_EN
   logic adel_q;
   assign misaligned = (pc[1:0] != 2'b00);
   assign if_adel    = adel_q;
`else
   assign misaligned = 1'b0;
   assign if_adel    = 1'b0;
`endif

   // a misaligned PC never reaches the bus
   assign inst_req  = (state == S_REQ) && !misaligned;
   assign inst_addr = pc;

   // a response is kept only if neither an earlier nor a simultaneous redirect hit this fetch
   assign deliver  = (state == S_WAIT) && inst_data_ok && !cancel && !redirect;
   // an address-error entry replaces the fetch unless a redirect arrives first
   assign adel_hit = (state == S_REQ) && misaligned && !redirect;
   // the held entry leaves on decode acceptance or on any redirect
   assign consume  = (state == S_HOLD) && (redirect || !stall);

   // sequencer: state, program counter and cancel flag
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state  <= S_IDLE;
         pc     <= RESET_PC;
         cancel <= 1'b0;
      end else begin
         case (state)
            S_IDLE: state <= S_REQ;
            S_REQ: begin
               if (inst_req && inst_addr_ok) begin
                  // request is out: the fetch is stale if a redirect coincides
                  pc     <= redirect ? target : pc_inc;
                  cancel <= redirect;
                  state  <= S_WAIT;
               end else if (redirect) begin
                  pc <= target;
               end else if (adel_hit) begin
                  state <= S_HOLD;
               end
            end
            S_WAIT: begin
               if (redirect) pc <= target;
               if (inst_data_ok) begin
                  cancel <= 1'b0;
                  state  <= deliver ? S_HOLD : S_REQ;
               end else if (redirect) begin
                  cancel <= 1'b1;
               end
            end
            S_HOLD: begin
               if (redirect) pc <= target;
               if (consume) state <= S_REQ;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // decode-facing output register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         if_valid <= 1'b0;
         if_pc    <= 32'd0;
         if_inst  <= 32'd0;
`ifdef PC_ALIGN_CHECK_EN
         adel_q   <= 1'b0;
`endif
      end else if (deliver || adel_hit) begin
         if_valid <= 1'b1;
         // after an accepted fetch pc already points one word past it
         if_pc    <= adel_hit ? pc : pc - 32'd4;
         if_inst  <= adel_hit ? 32'd0 : inst_rdata;
`ifdef PC_ALIGN_CHECK_EN
         adel_q   <= adel_hit;
`endif
      end else if (consume) begin
         if_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed and randomized bench for pc_fetch_ctrl.
// The bench plays the instruction memory; its reference model tracks only
// the architectural next-fetch address and the contents of memory.
module tb_pc_fetch_ctrl;

   localparam logic [31:0] RST_PC = 32'hBFC0_0000;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        stall = 1'b0;
   logic        br_taken = 1'b0;
   logic [31:0] br_target = 32'd0;
   logic        flush = 1'b0;
   logic [31:0] flush_target = 32'd0;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok = 1'b0;
   logic        inst_data_ok = 1'b0;
   logic [31:0] inst_rdata = 32'd0;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        if_adel;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          req_cyc = 0;
   logic [31:0] exp_pc;

   pc_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .resetn(resetn), .stall(stall),
      .br_taken(br_taken), .br_target(br_target),
      .flush(flush), .flush_target(flush_target),
      .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
      .inst_rdata(inst_rdata),
      .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_adel(if_adel)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // memory contents as a pure function of the word address
   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One fetch transaction. mode: 0 plain, 1 branch while waiting for data
   // (same cycle as data when ddly==0), 2 branch while holding, 3 flush+branch
   // alongside addr_ok, 4 branch while the request is pending.
   task automatic do_fetch(input int adly, input int ddly, input int nstall,
                           input int mode, input logic [31:0] tgt, input logic [31:0] ft);
      int          n;
      logic [31:0] addr;
      logic        cancelled;
      n = 0;
      cancelled = 1'b0;
      while (!inst_req && n < 20) begin
         step();
         n++;
      end
      chk("req_seen", {31'd0, inst_req}, 32'd1);
      if (!inst_req) return;
      req_cyc = cyc;
      chk("req_addr", inst_addr, exp_pc);
      if (mode == 4) begin
         br_taken = 1'b1; br_target = tgt;
         step();
         br_taken = 1'b0;
         exp_pc = tgt;
         chk("req_redir_addr", inst_addr, exp_pc);
      end
      for (int i = 0; i < adly; i++) begin
         inst_data_ok = (i == 0);
         inst_rdata = $urandom;
         step();
         inst_data_ok = 1'b0;
         chk("req_hold", {31'd0, inst_req}, 32'd1);
         chk("req_hold_addr", inst_addr, exp_pc);
         chk("req_noval", {31'd0, if_valid}, 32'd0);
      end
      addr = exp_pc;
      inst_addr_ok = 1'b1;
      if (mode == 3) begin
         flush = 1'b1; flush_target = ft;
         br_taken = 1'b1; br_target = tgt;
         cancelled = 1'b1;
      end
      step();
      inst_addr_ok = 1'b0; flush = 1'b0; br_taken = 1'b0;
      exp_pc = (mode == 3) ? ft : addr + 32'd4;
      chk("wait_noreq", {31'd0, inst_req}, 32'd0);
      for (int i = 0; i < ddly; i++) begin
         if (mode == 1 && i == 0) begin
            br_taken = 1'b1; br_target = tgt;
            cancelled = 1'b1;
            exp_pc = tgt;
         end
         step();
         br_taken = 1'b0;
         chk("wait_noval", {31'd0, if_valid}, 32'd0);
         chk("wait_noreq2", {31'd0, inst_req}, 32'd0);
      end
      if (mode == 1 && ddly == 0) begin
         br_taken = 1'b1; br_target = tgt;
         cancelled = 1'b1;
         exp_pc = tgt;
      end
      inst_data_ok = 1'b1; inst_rdata = mem(addr);
      step();
      inst_data_ok = 1'b0; br_taken = 1'b0; inst_rdata = $urandom;
      if (cancelled) begin
         chk("cancel_noval", {31'd0, if_valid}, 32'd0);
         chk("cancel_req", {31'd0, inst_req}, 32'd1);
         chk("cancel_addr", inst_addr, exp_pc);
         return;
      end
      chk("dlv_valid", {31'd0, if_valid}, 32'd1);
      chk("dlv_pc", if_pc, addr);
      chk("dlv_inst", if_inst, mem(addr));
      chk("dlv_adel", {31'd0, if_adel}, 32'd0);
      chk("dlv_noreq", {31'd0, inst_req}, 32'd0);
      stall = 1'b1;
      for (int i = 0; i < nstall; i++) begin
         inst_data_ok = 1'b1;
         step();
         inst_data_ok = 1'b0;
         chk("stall_valid", {31'd0, if_valid}, 32'd1);
         chk("stall_pc", if_pc, addr);
         chk("stall_inst", if_inst, mem(addr));
         chk("stall_noreq", {31'd0, inst_req}, 32'd0);
      end
      if (mode == 2) begin
         br_taken = 1'b1; br_target = tgt;
         stall = $urandom_range(0, 1);
         exp_pc = tgt;
      end else begin
         stall = 1'b0;
      end
      step();
      br_taken = 1'b0; stall = 1'b0;
      chk("cons_noval", {31'd0, if_valid}, 32'd0);
      chk("cons_req", {31'd0, inst_req}, 32'd1);
      chk("cons_addr", inst_addr, exp_pc);
   endtask

   initial begin
      int          c1;
      int          c2;
      int          m;
      int          mode;
      logic [31:0] t;
      logic [31:0] f;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_req", {31'd0, inst_req}, 32'd0);
      chk("rst_addr", inst_addr, RST_PC);
      chk("rst_valid", {31'd0, if_valid}, 32'd0);
      chk("rst_pc", if_pc, 32'd0);
      chk("rst_inst", if_inst, 32'd0);
      chk("rst_adel", {31'd0, if_adel}, 32'd0);
      resetn = 1'b1;
      chk("idle_noreq", {31'd0, inst_req}, 32'd0);
      step();
      chk("first_req", {31'd0, inst_req}, 32'd1);
      exp_pc = RST_PC;

      // back-to-back sequential fetches, one per three cycles
      do_fetch(0, 0, 0, 0, 32'd0, 32'd0);
      c1 = req_cyc;
      do_fetch(0, 0, 0, 0, 32'd0, 32'd0);
      c2 = req_cyc;
      chk("rate", c2 - c1, 32'd3);
      do_fetch(0, 0, 0, 0, 32'd0, 32'd0);
      chk("rate2", req_cyc - c2, 32'd3);
      chk("seq_pc", exp_pc, 32'hBFC0_000C);

      // stall holds the delivered entry
      do_fetch(1, 2, 5, 0, 32'd0, 32'd0);

      // redirects in each phase
      do_fetch(0, 2, 0, 1, 32'h8000_1000, 32'd0);
      chk("br_wait_addr", inst_addr, 32'h8000_1000);
      do_fetch(0, 1, 0, 3, 32'h8000_2000, 32'hBFC0_0380);
      chk("flush_wins", inst_addr, 32'hBFC0_0380);
      do_fetch(0, 0, 0, 1, 32'h8000_3000, 32'd0);
      do_fetch(2, 1, 1, 4, 32'h8000_4000, 32'd0);

      // PC wrap
      do_fetch(0, 0, 0, 2, 32'hFFFF_FFFC, 32'd0);
      do_fetch(0, 0, 0, 0, 32'd0, 32'd0);
      chk("wrap_addr", inst_addr, 32'd0);
      do_fetch(0, 0, 0, 0, 32'd0, 32'd0);

      // misaligned target
`ifdef PC_ALIGN_CHECK_EN
      br_taken = 1'b1; br_target = 32'h8000_0002;
      step();
      br_taken = 1'b0;
      chk("al_noreq", {31'd0, inst_req}, 32'd0);
      chk("al_addr", inst_addr, 32'h8000_0002);
      step();
      chk("al_valid", {31'd0, if_valid}, 32'd1);
      chk("al_adel", {31'd0, if_adel}, 32'd1);
      chk("al_pc", if_pc, 32'h8000_0002);
      chk("al_inst", if_inst, 32'd0);
      chk("al_noreq2", {31'd0, inst_req}, 32'd0);
      stall = 1'b1;
      step();
      chk("al_hold", {31'd0, if_adel}, 32'd1);
      stall = 1'b0; flush = 1'b1; flush_target = 32'hBFC0_0380;
      step();
      flush = 1'b0;
      chk("al_rec_val", {31'd0, if_valid}, 32'd0);
      chk("al_rec_req", {31'd0, inst_req}, 32'd1);
      chk("al_rec_addr", inst_addr, 32'hBFC0_0380);
      exp_pc = 32'hBFC0_0380;
      do_fetch(0, 0, 0, 0, 32'd0, 32'd0);
`else
      do_fetch(0, 0, 0, 4, 32'h8000_0002, 32'd0);
      do_fetch(0, 0, 0, 0, 32'd0, 32'd0);
      chk("mis_next", inst_addr, 32'h8000_000A);
`endif

      // reset during an outstanding fetch; late response is ignored
      inst_addr_ok = 1'b1;
      step();
      inst_addr_ok = 1'b0;
      #2 resetn = 1'b0;
      #1;
      chk("mid_rst_req", {31'd0, inst_req}, 32'd0);
      chk("mid_rst_addr", inst_addr, RST_PC);
      chk("mid_rst_val", {31'd0, if_valid}, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF;
      step();
      inst_data_ok = 1'b0;
      chk("late_req", {31'd0, inst_req}, 32'd1);
      chk("late_noval", {31'd0, if_valid}, 32'd0);
      chk("late_addr", inst_addr, RST_PC);
      exp_pc = RST_PC;

      // randomized traffic
      for (int k = 0; k < 40; k++) begin
         m = $urandom_range(0, 9);
         mode = (m < 5) ? 0 : (m < 7) ? 1 : (m < 8) ? 2 : (m < 9) ? 3 : 4;
         t = $urandom & 32'hFFFF_FFFC;
         f = $urandom & 32'hFFFF_FFFC;
         do_fetch($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3), mode, t, f);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
